uart_rx_fifo: RTL

Memory-mappable UART receiver for the SOC's IO page. It is the receive-side counterpart of the existing UART transmitter. It deserialises 8N1 frames from the RXD pin using a fixed integer clock divider and buffers complete bytes in a small first-word-fall-through FIFO. The CPU reads bytes through a pop strobe and polls the status flags.

---
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// CPU-side register interface of the UART receiver: pop/clear strobes in, FIFO head and status out.
interface uart_rx_fifo_if;
  logic       rd_strb;
  logic       clr_err;
  logic [7:0] rdata;
  logic       valid;
  logic       full;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  modport master (
    output rd_strb, clr_err,
    input  rdata, valid, full, overrun, frame_err, busy
  );

  modport slave (
    input  rd_strb, clr_err,
    output rdata, valid, full, overrun, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with fixed integer divider feeding a first-word-fall-through byte FIFO.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 1_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           rxd,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             rxd_m;
  logic             rs;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitidx;
  logic [7:0]       shreg;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             fifo_empty;
  logic             fifo_full;

  logic             cnt_zero;
  logic             push_req;
  logic             frame_evt;
  logic             do_pop;
  logic             do_push;
  logic             ovr_evt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_m <= 1'b1;
      rs    <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rs    <= rxd_m;
    end
  end

  assign cnt_zero  = (cnt == '0);
  assign push_req  = (state == S_STOP) && cnt_zero && rs;
  assign frame_evt = (state == S_STOP) && cnt_zero && !rs;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rs) begin
            cnt   <= HALF_LOAD;
            state <= S_START;
          end
        end
        S_START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (rs) begin
            state <= S_IDLE;
          end else begin
            cnt    <= FULL_LOAD;
            bitidx <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rs, shreg[7:1]};
            cnt   <= FULL_LOAD;
            if (bitidx == 3'd7) state  <= S_STOP;
            else                bitidx <= bitidx + 3'd1;
          end
        end
        S_STOP: begin
          if (!cnt_zero) cnt   <= cnt - 1'b1;
          else           state <= rs ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pop is resolved before push so a full FIFO can accept a byte on the same edge it is read.
  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop     = bus.rd_strb && !fifo_empty;
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign ovr_evt    = push_req && fifo_full && !do_pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.overrun   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (ovr_evt)          bus.overrun <= 1'b1;
      else if (bus.clr_err) bus.overrun <= 1'b0;
      if (frame_evt)        bus.frame_err <= 1'b1;
      else if (bus.clr_err) bus.frame_err <= 1'b0;
    end
  end

  assign bus.rdata = fifo_empty ? '0 : mem[rp[AW-1:0]];
  assign bus.valid = !fifo_empty;
  assign bus.full  = fifo_full;
  assign bus.busy  = (state != S_IDLE);

endmodule
